mem_responder: RTL and testbench

Memory-side responder for the cache-to-main-memory request interface. It accepts one request at a time from the cache's memory port and serves it from an internal byte-maskable storage array. Reads return one `MEM_DATA_BITS` beat after a fixed, parameterised latency; writes consume one data beat with a byte mask. It serves as the main-memory endpoint for cache simulation and as the synthesizable behavioural memory in the system testbench.

---
 rtl/mem_responder.sv | 77 +++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding main-memory endpoint with byte-masked writes and fixed-latency reads
module mem_responder #(
   parameter int MEM_DATA_BITS = 128,
   parameter int ADDR_BITS     = 28,
   parameter int DEPTH_LOG2    = 12,
   parameter int READ_LATENCY  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mem_req_val,
   output logic                       mem_req_rdy,
   input  logic [ADDR_BITS-1:0]       mem_req_addr,
   input  logic                       mem_req_rw,
   input  logic                       mem_req_data_valid,
   output logic                       mem_req_data_ready,
   input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
   input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
   output logic                       mem_resp_val,
   output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WDATA = 2'd1;
   localparam logic [1:0] RWAIT = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;
   localparam int NB = MEM_DATA_BITS / 8;
   localparam logic [3:0] LAT = 4'(READ_LATENCY);

   logic [1:0]               state;
   logic [3:0]               cnt;
   logic [DEPTH_LOG2-1:0]    idx;
   logic [MEM_DATA_BITS-1:0] rdata;
   logic [MEM_DATA_BITS-1:0] mem [2**DEPTH_LOG2];
   logic                     unused_addr;

   assign unused_addr = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

   // Request sequencing: accept, wait out the read latency, capture read data on entry to RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         rdata <= '0;
      end else begin
         case (state)
            IDLE: if (mem_req_val) begin
               idx <= mem_req_addr[DEPTH_LOG2-1:0];
               if (mem_req_rw) state <= WDATA;
               else if (LAT == 4'd1) begin
                  state <= RESP;
                  rdata <= mem[mem_req_addr[DEPTH_LOG2-1:0]];
               end else begin
                  state <= RWAIT;
                  cnt   <= LAT - 4'd1;
               end
            end
            WDATA: if (mem_req_data_valid) state <= IDLE;
            RWAIT: if (cnt == 4'd1) begin
               state <= RESP;
               rdata <= mem[idx];
            end else cnt <= cnt - 4'd1;
            default: state <= IDLE;
         endcase
      end
   end

   // Byte-masked storage update; a data beat coinciding with reset is dropped
   always_ff @(posedge clk) begin
      if (!reset && state == WDATA && mem_req_data_valid)
         for (int i = 0; i < NB; i++)
            if (mem_req_data_mask[i]) mem[idx][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
   end

   assign mem_req_rdy        = !reset && state == IDLE;
   assign mem_req_data_ready = !reset && state == WDATA;
   assign mem_resp_val       = !reset && state == RESP;
   assign mem_resp_data      = reset ? '0 : rdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against a behavioural memory model
module tb_mem_responder;
   localparam int LAT = 4;

   typedef struct {
      logic [127:0] d;
      int           c;
   } exp_t;

   logic         clk = 0;
   logic         reset = 1;
   logic         val = 0, rw = 0, dv = 0;
   logic [27:0]  addr = '0;
   logic [127:0] bits = '0;
   logic [15:0]  mask = '0;
   logic         rdy, dr, rv;
   logic [127:0] rd;
   logic         v1 = 0, rw1 = 0, dv1 = 0;
   logic [27:0]  a1 = '0;
   logic [127:0] b1 = '0;
   logic [15:0]  m1 = '0;
   logic         rdy1, dr1, rv1;
   logic [127:0] rd1;

   int checks = 0, errors = 0, cyc = 0, nresp = 0, nreads = 0;
   exp_t q[$];
   logic [127:0] model [4096];

   mem_responder #(.READ_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .mem_req_val(val), .mem_req_rdy(rdy), .mem_req_addr(addr), .mem_req_rw(rw),
      .mem_req_data_valid(dv), .mem_req_data_ready(dr),
      .mem_req_data_bits(bits), .mem_req_data_mask(mask),
      .mem_resp_val(rv), .mem_resp_data(rd)
   );

   mem_responder #(.READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .mem_req_val(v1), .mem_req_rdy(rdy1), .mem_req_addr(a1), .mem_req_rw(rw1),
      .mem_req_data_valid(dv1), .mem_req_data_ready(dr1),
      .mem_req_data_bits(b1), .mem_req_data_mask(m1),
      .mem_resp_val(rv1), .mem_resp_data(rd1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rv) begin
         nresp++;
         if (q.size() == 0) check("unexpected_resp", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("resp_data", rd, e.d);
            check("resp_cycle", 128'(cyc), 128'(e.c));
         end
      end
   end

   task automatic wait_rdy();
      int n = 0;
      while (!rdy && n < 100) begin
         step();
         n++;
      end
      check("rdy_wait", rdy, 1);
   endtask

   task automatic wr(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m, input int dly);
      wait_rdy();
      val = 1; rw = 1; addr = a;
      step();
      val = 0;
      repeat (dly) begin
         check("wdata_ready_hold", dr, 1);
         check("wdata_rdy_low", rdy, 0);
         step();
      end
      dv = 1; bits = d; mask = m;
      check("wdata_ready", dr, 1);
      step();
      dv = 0;
      for (int i = 0; i < 16; i++)
         if (m[i]) model[a[11:0]][8*i +: 8] = d[8*i +: 8];
      check("wdone_dready", dr, 0);
      check("wdone_rdy", rdy, 1);
   endtask

   task automatic rd_req(input logic [27:0] a, input bit hold);
      wait_rdy();
      val = 1; rw = 0; addr = a;
      step();
      q.push_back('{model[a[11:0]], cyc - 1 + LAT});
      nreads++;
      if (!hold) val = 0;
      for (int k = 1; k <= LAT; k++) begin
         check("rd_busy", rdy, 0);
         step();
      end
      val = 0;
      check("rd_rdy_again", rdy, 1);
   endtask

   task automatic check_reset_outs();
      check("rst_rdy", rdy, 0);
      check("rst_dready", dr, 0);
      check("rst_resp_val", rv, 0);
      check("rst_resp_data", rd, 0);
      check("rst_rdy1", rdy1, 0);
   endtask

   initial begin
      logic [11:0] bi [8];
      logic [127:0] d;
      repeat (3) begin
         step();
         check_reset_outs();
      end
      reset = 0;
      #1;
      check("post_reset_rdy", rdy, 1);
      check("post_reset_rdy1", rdy1, 1);

      wr(28'h5, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 16'hFFFF, 0);
      rd_req(28'h5, 0);
      wr(28'h5, '1, 16'h000F, 0);
      rd_req(28'h5, 0);
      wr(28'h1005, {16{8'hAA}}, 16'hFFFF, 5);
      rd_req(28'h5, 0);
      wr(28'h5, '1, 16'h0000, 1);
      rd_req(28'h2005, 0);
      rd_req(28'h5, 1);

      for (int i = 0; i < 8; i++) begin
         bi[i] = 12'($urandom);
         wr({16'($urandom), bi[i]}, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 0);
      end
      for (int n = 0; n < 60; n++) begin
         logic [27:0] a;
         a = {16'($urandom), bi[$urandom_range(0, 7)]};
         if ($urandom_range(0, 1) == 1)
            wr(a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), $urandom_range(0, 3));
         else
            rd_req(a, $urandom_range(0, 3) == 0);
      end

      wait_rdy();
      val = 1; rw = 0; addr = 28'h5;
      step();
      val = 0;
      step();
      reset = 1;
      q.delete();
      repeat (2) begin
         step();
         check_reset_outs();
      end
      reset = 0;
      #1;
      check("mid_read_reset_rdy", rdy, 1);
      repeat (8) step();

      d = {$urandom, $urandom, $urandom, $urandom};
      check("l1_rdy", rdy1, 1);
      v1 = 1; rw1 = 1; a1 = 28'h3;
      step();
      v1 = 0; dv1 = 1; b1 = d; m1 = 16'hFFFF;
      check("l1_dready", dr1, 1);
      step();
      dv1 = 0;
      v1 = 1; rw1 = 0; a1 = 28'h1003;
      check("l1_rdy_read", rdy1, 1);
      step();
      v1 = 0;
      check("l1_resp_val", rv1, 1);
      check("l1_resp_data", rd1, d);
      check("l1_busy", rdy1, 0);
      step();
      check("l1_resp_done", rv1, 0);
      check("l1_rdy_after", rdy1, 1);
      v1 = 1; rw1 = 0; a1 = 28'h3;
      step();
      v1 = 0;
      check("l1_resp_val2", rv1, 1);
      check("l1_resp_data2", rd1, d);
      step();
      reset = 1;
      step();
      check("l1_rst_resp_val", rv1, 0);
      check("l1_rst_rdy", rdy1, 0);
      reset = 0;
      #1;
      check("l1_post_reset_rdy", rdy1, 1);
      step();
      check("l1_no_resp", rv1, 0);

      repeat (4) step();
      check("resp_count", 128'(nresp), 128'(nreads));
      check("sb_empty", 128'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
